// File: rtl/ps2_scan_decoder_if.sv
// Bus between the PS/2 byte receiver, the scan-code decoder and the console stage.
// in_valid is a one-cycle strobe with no ready; evt_valid is a one-cycle pulse with no backpressure.
interface ps2_scan_decoder_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       evt_valid;
   logic       evt_make;
   logic       evt_ext;
   logic [7:0] evt_code;
   logic [7:0] evt_ascii;
   logic       key_held;
   logic [7:0] held_code;
   logic [7:0] press_count;
   logic       shift_held;
   logic [1:0] dbg_state;

   modport master (
      output in_valid, in_data,
      input  evt_valid, evt_make, evt_ext, evt_code, evt_ascii,
      input  key_held, held_code, press_count, shift_held, dbg_state
   );

   modport slave (
      input  in_valid, in_data,
      output evt_valid, evt_make, evt_ext, evt_code, evt_ascii,
      output key_held, held_code, press_count, shift_held, dbg_state
   );
endinterface

// File: rtl/ps2_scan_decoder.sv
// Set-2 scan-code decoder: prefix stripping, typematic suppression, held-key tracking, ASCII map.
// Optional macro PS2_SHIFT_EN enables Shift tracking and shifted ASCII.
module ps2_scan_decoder (
   input logic                  clk,
   input logic                  rst_n,
   ps2_scan_decoder_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } state_t;

   state_t     state;
   state_t     next_state;
   logic       fin;
   logic       fin_ext;
   logic       fin_brk;
   logic       is_mod;
   logic       held_match;
   logic [7:0] ascii_now;

   logic       evt_valid_r;
   logic       evt_make_r;
   logic       evt_ext_r;
   logic [7:0] evt_code_r;
   logic [7:0] evt_ascii_r;
   logic       key_held_r;
   logic       held_ext_r;
   logic [7:0] held_code_r;
   logic [7:0] press_count_r;
   logic       shift_held_w;

   function automatic logic [7:0] base_ascii(input logic [7:0] code);
      logic [7:0] a;
      case (code)
         8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
         8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
         8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
         8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
         8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
         8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
         8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
         8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
         8'h3E: a = 8'h38; 8'h46: a = 8'h39;
         8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
         default: a = 8'h00;
      endcase
      return a;
   endfunction

`ifdef PS2_SHIFT_EN
   logic shift_l;
   logic shift_r;

   // Letters shift by clearing bit 5; digits use the US keyboard symbol row.
   function automatic logic [7:0] shifted_ascii(input logic [7:0] code);
      logic [7:0] b;
      logic [7:0] a;
      b = base_ascii(code);
      case (code)
         8'h16: a = 8'h21; 8'h1E: a = 8'h40; 8'h26: a = 8'h23; 8'h25: a = 8'h24;
         8'h2E: a = 8'h25; 8'h36: a = 8'h5E; 8'h3D: a = 8'h26; 8'h3E: a = 8'h2A;
         8'h46: a = 8'h28; 8'h45: a = 8'h29;
         default: a = (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
      endcase
      return a;
   endfunction

   assign shift_held_w = shift_l | shift_r;
`else
   assign shift_held_w = 1'b0;
`endif

   always_comb begin
      next_state = state;
      fin        = 1'b0;
      fin_ext    = 1'b0;
      fin_brk    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_data == 8'hE0)      next_state = EXT;
            else if (bus.in_data == 8'hF0) next_state = BRK;
            else if (bus.in_data == 8'h00 || bus.in_data == 8'hAA ||
                     bus.in_data == 8'hE1 || bus.in_data == 8'hEE ||
                     bus.in_data == 8'hFA || bus.in_data == 8'hFE ||
                     bus.in_data == 8'hFF) next_state = IDLE;
            else                           fin = 1'b1;
         end
         EXT: begin
            if (bus.in_data == 8'hF0)      next_state = EXT_BRK;
            else if (bus.in_data == 8'hE0) next_state = EXT;
            else begin
               fin     = 1'b1;
               fin_ext = 1'b1;
            end
         end
         BRK: begin
            if (bus.in_data == 8'hE0)      next_state = EXT_BRK;
            else if (bus.in_data == 8'hF0) next_state = BRK;
            else begin
               fin     = 1'b1;
               fin_brk = 1'b1;
            end
         end
         default: begin
            if (bus.in_data == 8'hE0 || bus.in_data == 8'hF0) next_state = EXT_BRK;
            else begin
               fin     = 1'b1;
               fin_ext = 1'b1;
               fin_brk = 1'b1;
            end
         end
      endcase
      if (fin) next_state = IDLE;
      fin = fin & bus.in_valid;
   end

   assign is_mod     = !fin_ext && (bus.in_data == 8'h12 || bus.in_data == 8'h59);
   assign held_match = key_held_r && (held_ext_r == fin_ext) && (held_code_r == bus.in_data);

   always_comb begin
      ascii_now = 8'h00;
      if (!fin_ext) begin
`ifdef PS2_SHIFT_EN
         ascii_now = shift_held_w ? shifted_ascii(bus.in_data) : base_ascii(bus.in_data);
`else
         ascii_now = base_ascii(bus.in_data);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         evt_valid_r   <= 1'b0;
         evt_make_r    <= 1'b0;
         evt_ext_r     <= 1'b0;
         evt_code_r    <= 8'h00;
         evt_ascii_r   <= 8'h00;
         key_held_r    <= 1'b0;
         held_ext_r    <= 1'b0;
         held_code_r   <= 8'h00;
         press_count_r <= 8'h00;
`ifdef PS2_SHIFT_EN
         shift_l       <= 1'b0;
         shift_r       <= 1'b0;
`endif
      end else begin
         evt_valid_r <= 1'b0;
         if (bus.in_valid) state <= next_state;
         if (fin) begin
            if (is_mod) begin
`ifdef PS2_SHIFT_EN
               if (bus.in_data == 8'h12) shift_l <= !fin_brk;
               else                      shift_r <= !fin_brk;
`endif
            end else if (!fin_brk) begin
               // A make of the key already down is typematic repeat and is swallowed.
               if (!held_match) begin
                  evt_valid_r   <= 1'b1;
                  evt_make_r    <= 1'b1;
                  evt_ext_r     <= fin_ext;
                  evt_code_r    <= bus.in_data;
                  evt_ascii_r   <= ascii_now;
                  key_held_r    <= 1'b1;
                  held_ext_r    <= fin_ext;
                  held_code_r   <= bus.in_data;
                  press_count_r <= press_count_r + 8'd1;
               end
            end else begin
               evt_valid_r <= 1'b1;
               evt_make_r  <= 1'b0;
               evt_ext_r   <= fin_ext;
               evt_code_r  <= bus.in_data;
               evt_ascii_r <= ascii_now;
               if (held_match) begin
                  key_held_r  <= 1'b0;
                  held_ext_r  <= 1'b0;
                  held_code_r <= 8'h00;
               end
            end
         end
      end
   end

   assign bus.evt_valid   = evt_valid_r;
   assign bus.evt_make    = evt_make_r;
   assign bus.evt_ext     = evt_ext_r;
   assign bus.evt_code    = evt_code_r;
   assign bus.evt_ascii   = evt_ascii_r;
   assign bus.key_held    = key_held_r;
   assign bus.held_code   = held_code_r;
   assign bus.press_count = press_count_r;
   assign bus.shift_held  = shift_held_w;
   assign bus.dbg_state   = state;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: expected events are queued by the driver and popped by a monitor.
module tb_ps2_scan_decoder;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   n_push;
   int   n_evt;
   logic [35:0] exp_q[$];

   ps2_scan_decoder_if bus ();

   ps2_scan_decoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed event: {make, ext, code, ascii, key_held, held_code, press_count, shift_held}
   function automatic logic [35:0] pk(input logic mk, input logic ex, input logic [7:0] cd,
                                      input logic [7:0] as, input logic kh, input logic [7:0] hc,
                                      input logic [7:0] pc, input logic sh);
      return {mk, ex, cd, as, kh, hc, pc, sh};
   endfunction

   task automatic push_evt(input logic [35:0] e);
      exp_q.push_back(e);
      n_push++;
   endtask

   task automatic send(input logic [7:0] b);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // Monitor: every evt_valid pulse must match the head of the expected queue.
   always @(negedge clk) begin
      logic [35:0] act;
      logic [35:0] e;
      if (rst_n && bus.evt_valid) begin
         act = {bus.evt_make, bus.evt_ext, bus.evt_code, bus.evt_ascii,
                bus.key_held, bus.held_code, bus.press_count, bus.shift_held};
         checks++;
         n_evt++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL evt_unexpected act=%h", act);
         end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
               errors++;
               $display("FAIL evt_%0d act=%h exp=%h", n_evt, act, e);
            end
         end
      end
   end

   initial begin
      logic [7:0] sh_ascii;
      logic       sh_bit;
      logic [7:0] cd;
      logic [7:0] as;
      int         wait_cnt;
      checks = 0;
      errors = 0;
      n_push = 0;
      n_evt  = 0;
      rst_n  = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_evt_valid", {7'd0, bus.evt_valid}, 8'h00);
      chk("rst_evt_make",  {7'd0, bus.evt_make}, 8'h00);
      chk("rst_evt_ext",   {7'd0, bus.evt_ext}, 8'h00);
      chk("rst_evt_code",  bus.evt_code, 8'h00);
      chk("rst_evt_ascii", bus.evt_ascii, 8'h00);
      chk("rst_key_held",  {7'd0, bus.key_held}, 8'h00);
      chk("rst_held_code", bus.held_code, 8'h00);
      chk("rst_press_cnt", bus.press_count, 8'h00);
      chk("rst_shift",     {7'd0, bus.shift_held}, 8'h00);
      chk("rst_state",     {6'd0, bus.dbg_state}, 8'h00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic make/break of 'a'.
      push_evt(pk(1'b1, 1'b0, 8'h1C, 8'h61, 1'b1, 8'h1C, 8'd1, 1'b0));
      push_evt(pk(1'b0, 1'b0, 8'h1C, 8'h61, 1'b0, 8'h00, 8'd1, 1'b0));
      send(8'h1C); send(8'hF0); send(8'h1C);

      // Typematic repeats collapse to one make.
      push_evt(pk(1'b1, 1'b0, 8'h1C, 8'h61, 1'b1, 8'h1C, 8'd2, 1'b0));
      push_evt(pk(1'b0, 1'b0, 8'h1C, 8'h61, 1'b0, 8'h00, 8'd2, 1'b0));
      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);

      // Extended cursor key.
      push_evt(pk(1'b1, 1'b1, 8'h75, 8'h00, 1'b1, 8'h75, 8'd3, 1'b0));
      push_evt(pk(1'b0, 1'b1, 8'h75, 8'h00, 1'b0, 8'h00, 8'd3, 1'b0));
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      @(negedge clk);
      chk("ext_key_held", {7'd0, bus.key_held}, 8'h00);

      // Shifted 'a'.
`ifdef PS2_SHIFT_EN
      sh_ascii = 8'h41;
      sh_bit   = 1'b1;
`else
      sh_ascii = 8'h61;
      sh_bit   = 1'b0;
`endif
      push_evt(pk(1'b1, 1'b0, 8'h1C, sh_ascii, 1'b1, 8'h1C, 8'd4, sh_bit));
      push_evt(pk(1'b0, 1'b0, 8'h1C, sh_ascii, 1'b0, 8'h00, 8'd4, sh_bit));
      @(posedge clk); #1;
      send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
      @(negedge clk);
      chk("shift_released", {7'd0, bus.shift_held}, 8'h00);
      chk("shift_no_count", bus.press_count, 8'd4);

      // Counter wrap over 256 presses with ignorable bytes interleaved.
      repeat (3) @(posedge clk);
      #1;
      do_reset();
      for (int i = 0; i < 256; i++) begin
         cd = (i % 2 == 0) ? 8'h1C : 8'h32;
         as = (i % 2 == 0) ? 8'h61 : 8'h62;
         push_evt(pk(1'b1, 1'b0, cd, as, 1'b1, cd, 8'((i + 1) % 256), 1'b0));
         push_evt(pk(1'b0, 1'b0, cd, as, 1'b0, 8'h00, 8'((i + 1) % 256), 1'b0));
         send(8'hAA); send(cd); send(8'hFA); send(8'hF0); send(cd);
      end
      @(negedge clk);
      chk("wrap_count", bus.press_count, 8'h00);

      // Reset in the middle of an E0 sequence.
      repeat (3) @(posedge clk);
      #1;
      push_evt(pk(1'b1, 1'b0, 8'h1C, 8'h61, 1'b1, 8'h1C, 8'd1, 1'b0));
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hE0;
      @(posedge clk); #1;
      rst_n        = 1'b0;
      bus.in_data  = 8'h55;
      @(posedge clk); #1;
      rst_n        = 1'b1;
      bus.in_data  = 8'h1C;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;

      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 20) begin
         @(posedge clk);
         wait_cnt++;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("queue_drained", 8'(exp_q.size()), 8'd0);
      chk("event_total", 8'(n_evt % 256), 8'(n_push % 256));
      chk("final_held", {7'd0, bus.key_held}, 8'h01);
      chk("final_held_code", bus.held_code, 8'h1C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
